prog_loader: RTL and testbench

- Byte-stream program loader that writes 32-bit instruction words into the CPU's instruction memory write port. It is the writer for the instruction ROM the CPU reads.
- Sits between a byte source (UART RX or testbench) and the instruction memory.
- Holds the CPU via cpu_hold until the image is fully written, then releases it.

---
 rtl/prog_loader.sv | 192 +++++++++++++++++++
 tb/tb_prog_loader.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// prog_loader: byte-stream program loader for the CPU instruction memory.
// Stream is big-endian: a ceil(CNT_W/8)-byte word count N, then N 32-bit
// words sent MSB first. The CPU is held off (cpu_hold) until the image is in.
// Words whose index does not fit in INSTR_AW bits are consumed but not
// written, and they raise the sticky err flag.
// Optional build macro PROG_LOADER_CHECKSUM_EN: a trailing XOR checksum byte
// over the payload is expected after the last word (CHK state).
module prog_loader #(
  parameter int INSTR_AW = 10,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                in_valid,
  input  logic [7:0]          in_data,
  output logic                in_ready,
  output logic                imem_we,
  output logic [INSTR_AW-1:0] imem_addr,
  output logic [31:0]         imem_wdata,
  output logic                cpu_hold,
  output logic                done,
  output logic                err
);

  localparam int HDR_B = (CNT_W + 7) / 8;
  localparam int HDR_W = HDR_B * 8;

`ifdef PROG_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {LEN_HI, LEN_LO, DATA, WRITE, CHK, DONE} state_t;
`else
  typedef enum logic [2:0] {LEN_HI, LEN_LO, DATA, WRITE, DONE} state_t;
`endif

  state_t               state_q, state_d;
  logic [HDR_W-1:0]     hdr_q;
  logic [HDR_W-1:0]     hdr_next;
  logic [CNT_W-1:0]     n_cur, n_next;
  logic [7:0]           hcnt_q;
  logic [1:0]           bcnt_q;
  logic [31:0]          asm_q;
  logic [31:0]          word_next;
  logic [CNT_W-1:0]     idx_q;
  logic [INSTR_AW-1:0]  addr_q;
  logic [31:0]          wdata_q;
  logic                 err_q;
  logic                 accept;
  logic                 ovf;
  logic                 last_word;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0]           csum_q;
`endif

  assign accept    = in_valid && in_ready;
  assign hdr_next  = (hdr_q << 8) | HDR_W'(in_data);
  assign n_next    = hdr_next[CNT_W-1:0];
  assign n_cur     = hdr_q[CNT_W-1:0];
  assign word_next = {asm_q[23:0], in_data};
  // An index with any bit at or above INSTR_AW has no memory slot.
  assign ovf       = (idx_q >> INSTR_AW) != '0;
  assign last_word = (idx_q + CNT_W'(1)) == n_cur;

  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign err        = err_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= LEN_HI;
    else        state_q <= state_d;
  end

  // Next-state decode and control outputs.
  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    imem_we  = 1'b0;
    cpu_hold = 1'b1;
    done     = 1'b0;
    case (state_q)
      LEN_HI, LEN_LO: begin
        in_ready = rst_n;
        if (accept) begin
          if (state_q == LEN_HI && HDR_B > 1) begin
            // Stay in LEN_HI until only the final header byte is left.
            if (hcnt_q == 8'(HDR_B - 2)) state_d = LEN_LO;
          end else if (n_next == '0) begin
`ifdef PROG_LOADER_CHECKSUM_EN
            state_d = CHK;
`else
            state_d = DONE;
`endif
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        in_ready = rst_n;
        if (accept && bcnt_q == 2'd3) state_d = WRITE;
      end
      WRITE: begin
        imem_we = !ovf;
        if (last_word) begin
`ifdef PROG_LOADER_CHECKSUM_EN
          state_d = CHK;
`else
          state_d = DONE;
`endif
        end else begin
          state_d = DATA;
        end
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      CHK: begin
        in_ready = rst_n;
        if (accept) state_d = DONE;
      end
`endif
      DONE: begin
        cpu_hold = 1'b0;
        done     = 1'b1;
        if (start) state_d = LEN_HI;
      end
      default: state_d = LEN_HI;
    endcase
  end

  // Header capture, word assembly, write-port registers and error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hdr_q   <= '0;
      hcnt_q  <= '0;
      bcnt_q  <= '0;
      asm_q   <= '0;
      idx_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      case (state_q)
        LEN_HI, LEN_LO: begin
          if (accept) begin
            hdr_q  <= hdr_next;
            hcnt_q <= hcnt_q + 8'd1;
          end
        end
        DATA: begin
          if (accept) begin
            asm_q  <= word_next;
            bcnt_q <= bcnt_q + 2'd1;
`ifdef PROG_LOADER_CHECKSUM_EN
            csum_q <= csum_q ^ in_data;
`endif
            // Only in-range words update the write port, so the address
            // never wraps back onto an earlier word.
            if (bcnt_q == 2'd3 && !ovf) begin
              addr_q  <= INSTR_AW'(idx_q);
              wdata_q <= word_next;
            end
          end
        end
        WRITE: begin
          idx_q <= idx_q + CNT_W'(1);
          if (ovf) err_q <= 1'b1;
        end
`ifdef PROG_LOADER_CHECKSUM_EN
        CHK: begin
          if (accept && in_data != csum_q) err_q <= 1'b1;
        end
`endif
        DONE: begin
          if (start) begin
            err_q  <= 1'b0;
            idx_q  <= '0;
            hdr_q  <= '0;
            hcnt_q <= '0;
            bcnt_q <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
            csum_q <= '0;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader with a 4-word instruction memory so overflow is
// easy to reach. Expected writes come from the stream itself: word i of an
// N-word image lands at address i when i < 4; everything else only sets err.
module tb_prog_loader;
  localparam int AW    = 2;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          in_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          cpu_hold;
  logic          done;
  logic          err;

  int n_assert = 0;
  int n_fail   = 0;

  int unsigned wa_q[$];
  logic [31:0] wd_q[$];
  logic        wr_q[$];
  logic [31:0] wq[$];
`ifdef PROG_LOADER_CHECKSUM_EN
  bit          ck_bad = 1'b0;
`endif

  always #5 clk = ~clk;

  prog_loader #(.INSTR_AW(AW), .CNT_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .err        (err)
  );

  // Record every memory write, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n && imem_we) begin
      wa_q.push_back(int'(imem_addr));
      wd_q.push_back(imem_wdata);
      wr_q.push_back(in_ready);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
    n_assert++;
    assert (obs === req) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, req);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    for (int i = 0; i < gap; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    t = 0;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) begin
      chk("byte_timeout", in_ready, 1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("restart_hold", cpu_hold, 1);
    chk("restart_done", done, 0);
    chk("restart_err", err, 0);
    chk("restart_ready", in_ready, 1);
  endtask

  // Stream an N-word image from wq and check it against the expected writes.
  task automatic run_load(input int n, input int gap, input bit poke);
    logic [7:0]  bytes[$];
    logic [15:0] nn;
    logic [31:0] tw;
    logic [7:0]  ck;
    int          g;
    int          nexp;
    int          t;
    logic        exp_err;
    wa_q.delete();
    wd_q.delete();
    wr_q.delete();
    nn = 16'(n);
    bytes.push_back(nn[15:8]);
    bytes.push_back(nn[7:0]);
    ck = 8'h00;
    for (int i = 0; i < n; i++) begin
      tw = wq[i];
      for (int b = 3; b >= 0; b--) begin
        bytes.push_back(tw[8*b +: 8]);
        ck = ck ^ tw[8*b +: 8];
      end
    end
    exp_err = (n > DEPTH);
`ifdef PROG_LOADER_CHECKSUM_EN
    bytes.push_back(ck ^ (ck_bad ? 8'h01 : 8'h00));
    exp_err = exp_err | ck_bad;
`endif
    for (int i = 0; i < bytes.size(); i++) begin
      g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
      if (poke && i == 3) begin
        // start outside DONE must be ignored
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
      send_byte(bytes[i], g);
    end
`ifdef PROG_LOADER_CHECKSUM_EN
    chk("done_lat", done, 1);
`else
    if (n > 0) begin
      chk("we_lat", imem_we, (n <= DEPTH));
      chk("ready_in_write", in_ready, 0);
      @(posedge clk);
      #1;
      chk("done_lat", done, 1);
    end else begin
      @(posedge clk);
      #1;
      chk("done_lat", done, 1);
    end
`endif
    t = 0;
    while (!done && t < 20) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("done", done, 1);
    chk("cpu_hold", cpu_hold, 0);
    chk("ready_done", in_ready, 0);
    chk("we_done", imem_we, 0);
    nexp = (n < DEPTH) ? n : DEPTH;
    chk("wr_count", wa_q.size(), nexp);
    for (int i = 0; i < nexp && i < wa_q.size(); i++) begin
      chk("wr_addr", wa_q[i], i);
      chk("wr_data", wd_q[i], wq[i]);
      chk("wr_ready_low", wr_q[i], 0);
    end
    chk("err", err, exp_err);
  endtask

  initial begin
    // Reset values
    #1;
    chk("rst_ready", in_ready, 0);
    chk("rst_we", imem_we, 0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_wdata", imem_wdata, 0);
    chk("rst_hold", cpu_hold, 1);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Basic two-word load, back-to-back bytes
    wq = {};
    wq.push_back(32'hDEADBEEF);
    wq.push_back(32'h12345678);
    run_load(2, 0, 1'b0);

    // Empty image
    pulse_start();
    wq = {};
    run_load(0, 0, 1'b0);

    // Stalled source, with a stray start mid-load
    pulse_start();
    wq = {};
    wq.push_back(32'hDEADBEEF);
    wq.push_back(32'h12345678);
    run_load(2, 3, 1'b1);

    // Overflow past the 4-word memory
    pulse_start();
    wq = {};
    for (int i = 1; i <= 5; i++) wq.push_back(32'(i));
    run_load(5, 0, 1'b0);
    chk("ovf_last_addr", imem_addr, 3);
    chk("ovf_last_data", imem_wdata, 32'd4);

    // Restart clears err
    pulse_start();
    wq = {};
    wq.push_back(32'h00000001);
    run_load(1, 0, 1'b0);

    // Reset in the middle of a load
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    send_byte(8'hDE, 0);
    send_byte(8'hAD, 0);
    send_byte(8'hBE, 0);
    send_byte(8'hEF, 0);
    chk("mid_we", imem_we, 1);
    chk("mid_wdata", imem_wdata, 32'hDEADBEEF);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_we", imem_we, 0);
    chk("mid_rst_addr", imem_addr, 0);
    chk("mid_rst_wdata", imem_wdata, 0);
    chk("mid_rst_hold", cpu_hold, 1);
    chk("mid_rst_ready", in_ready, 0);
    chk("mid_rst_done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    wq = {};
    wq.push_back(32'hCAFEF00D);
    run_load(1, 0, 1'b0);

    // Random images with random stalls
    for (int k = 0; k < 8; k++) begin
      int n;
      pulse_start();
      n = int'($urandom_range(0, 6));
      wq = {};
      for (int i = 0; i < n; i++) wq.push_back($urandom());
      run_load(n, -1, 1'b0);
    end

`ifdef PROG_LOADER_CHECKSUM_EN
    // Good and bad checksum byte
    pulse_start();
    wq = {};
    wq.push_back(32'h01020304);
    ck_bad = 1'b0;
    run_load(1, 0, 1'b0);
    pulse_start();
    ck_bad = 1'b1;
    run_load(1, 0, 1'b0);
    ck_bad = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
